// File: rtl/scs8hd_ano_pipe.sv
// Two-stage valid/ready pipeline around a parametrised AND-OR (optionally inverted) function,
// with a saturating count of delivered high results. Latency 2, full throughput, IN_READY comb from OUT_READY.
module scs8hd_ano_pipe #(
  parameter int NUM_TERMS  = 2,
  parameter int TERM_WIDTH = 4,
  parameter int NUM_B      = 1,
  parameter int INVERT     = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            CLK,
  input  logic                            RESETB,
  input  logic [NUM_TERMS*TERM_WIDTH-1:0] A,
  input  logic [NUM_B-1:0]                B,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  output logic                            X,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  input  logic                            CNT_CLR,
  output logic [CNT_WIDTH-1:0]            HI_COUNT
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic                 INV_BIT = (INVERT != 0);

  logic                 s1_valid_q, s1_valid_d;
  logic [NUM_TERMS-1:0] s1_p_q, s1_p_d;
  logic                 s1_b_q, s1_b_d;
  logic                 s2_valid_q, s2_valid_d;
  logic                 x_q, x_d;
  logic [CNT_WIDTH-1:0] hi_count_q, hi_count_d;
  logic                 adv2, in_ready, in_xfer, out_xfer;

  always_comb begin
    adv2     = s1_valid_q & (~s2_valid_q | OUT_READY);
    in_ready = ~s1_valid_q | adv2;
    in_xfer  = IN_VALID & in_ready;
    out_xfer = s2_valid_q & OUT_READY;

    s1_valid_d = in_xfer | (s1_valid_q & ~adv2);
    s1_p_d     = s1_p_q;
    s1_b_d     = s1_b_q;
    if (in_xfer) begin
      for (int k = 0; k < NUM_TERMS; k++) begin
        s1_p_d[k] = &A[k*TERM_WIDTH +: TERM_WIDTH];
      end
      s1_b_d = |B;
    end

    s2_valid_d = adv2 | (s2_valid_q & ~OUT_READY);
    // adv2 already implies stage 2 is empty or draining, so X never changes under a stall.
    x_d = adv2 ? ((|s1_p_q | s1_b_q) ^ INV_BIT) : x_q;

    hi_count_d = hi_count_q;
    if (CNT_CLR) begin
      hi_count_d = '0;
    end else if (out_xfer && x_q && (hi_count_q != CNT_MAX)) begin
      hi_count_d = hi_count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_b_q     <= 1'b0;
      s2_valid_q <= 1'b0;
      x_q        <= 1'b0;
      hi_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_p_q     <= s1_p_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      x_q        <= x_d;
      hi_count_q <= hi_count_d;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = s2_valid_q;
  assign X         = x_q;
  assign HI_COUNT  = hi_count_q;

endmodule

// File: tb/tb_scs8hd_ano_pipe.sv
// Drives three builds (default, inverted with 2-bit counter, wide 4x8/NB=3) from one stimulus stream
// and checks each against a latency-2 / capacity-2 queue model of the pipeline.
module tb_scs8hd_ano_pipe;

  logic        CLK;
  logic        rst_n;
  logic [31:0] a_in;
  logic [2:0]  b_in;
  logic        in_vld, out_rdy, cnt_clr;

  logic        rdy_b, x_b, ov_b;
  logic [15:0] hc_b;
  logic        rdy_i, x_i, ov_i;
  logic [1:0]  hc_i;
  logic        rdy_w, x_w, ov_w;
  logic [15:0] hc_w;

  scs8hd_ano_pipe u_base (
    .CLK(CLK), .RESETB(rst_n), .A(a_in[7:0]), .B(b_in[0:0]), .IN_VALID(in_vld),
    .IN_READY(rdy_b), .X(x_b), .OUT_VALID(ov_b), .OUT_READY(out_rdy),
    .CNT_CLR(cnt_clr), .HI_COUNT(hc_b));

  scs8hd_ano_pipe #(.INVERT(1), .CNT_WIDTH(2)) u_inv (
    .CLK(CLK), .RESETB(rst_n), .A(a_in[7:0]), .B(b_in[0:0]), .IN_VALID(in_vld),
    .IN_READY(rdy_i), .X(x_i), .OUT_VALID(ov_i), .OUT_READY(out_rdy),
    .CNT_CLR(cnt_clr), .HI_COUNT(hc_i));

  scs8hd_ano_pipe #(.NUM_TERMS(4), .TERM_WIDTH(8), .NUM_B(3)) u_wide (
    .CLK(CLK), .RESETB(rst_n), .A(a_in), .B(b_in), .IN_VALID(in_vld),
    .IN_READY(rdy_w), .X(x_w), .OUT_VALID(ov_w), .OUT_READY(out_rdy),
    .CNT_CLR(cnt_clr), .HI_COUNT(hc_w));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: accepted items wait in order; the oldest is visible two edges after acceptance.
  int          acc_q[$];
  logic        qb[$], qi[$], qw[$];
  int unsigned cnt_b, cnt_i, cnt_w;
  int          cyc_n;
  logic        last_acc, last_rdy;

  typedef struct {
    logic [31:0] a;
    logic [2:0]  b;
    logic        x_base;
    logic        x_inv;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc_n, act, exp);
    end
  endtask

  function automatic logic f_base(input logic [31:0] a, input logic [2:0] b);
    return (a[3:0] == 4'hF) || (a[7:4] == 4'hF) || (b[0] == 1'b1);
  endfunction

  function automatic logic f_wide(input logic [31:0] a, input logic [2:0] b);
    logic hit;
    hit = (b != 3'b000);
    for (int k = 0; k < 4; k++) if (((a >> (8 * k)) & 32'hFF) == 32'hFF) hit = 1'b1;
    return hit;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned c, input int unsigned mx);
    return (c < mx) ? c + 1 : c;
  endfunction

  task automatic clear_model();
    acc_q.delete(); qb.delete(); qi.delete(); qw.delete();
    cnt_b = 0; cnt_i = 0; cnt_w = 0;
  endtask

  // One clock: drive inputs just after a rising edge, check on the falling edge, advance the model.
  task automatic cyc(input logic iv, input logic [31:0] a, input logic [2:0] b, input logic ordy,
                     input logic clr, input logic use_tbl, input logic tb_b, input logic tb_i);
    logic vis, rdy_e, in_x, out_x;
    in_vld = iv; a_in = a; b_in = b; out_rdy = ordy; cnt_clr = clr;
    @(negedge CLK);
    vis   = (acc_q.size() > 0) && (cyc_n - acc_q[0] >= 2);
    rdy_e = (acc_q.size() < 2) || ordy;
    chk("in_ready_base", rdy_b, rdy_e);
    chk("in_ready_inv",  rdy_i, rdy_e);
    chk("in_ready_wide", rdy_w, rdy_e);
    chk("out_valid_base", ov_b, vis);
    chk("out_valid_inv",  ov_i, vis);
    chk("out_valid_wide", ov_w, vis);
    if (vis) begin
      chk("x_base", x_b, qb[0]);
      chk("x_inv",  x_i, qi[0]);
      chk("x_wide", x_w, qw[0]);
    end
    chk("hi_count_base", hc_b, cnt_b);
    chk("hi_count_inv",  hc_i, cnt_i);
    chk("hi_count_wide", hc_w, cnt_w);
    last_rdy = rdy_b;
    in_x  = iv && rdy_e;
    out_x = vis && ordy;
    last_acc = in_x;
    if (out_x) begin
      if (qb[0]) cnt_b = sat_inc(cnt_b, 65535);
      if (qi[0]) cnt_i = sat_inc(cnt_i, 3);
      if (qw[0]) cnt_w = sat_inc(cnt_w, 65535);
      void'(acc_q.pop_front()); void'(qb.pop_front());
      void'(qi.pop_front()); void'(qw.pop_front());
    end
    if (clr) begin
      cnt_b = 0; cnt_i = 0; cnt_w = 0;
    end
    if (in_x) begin
      acc_q.push_back(cyc_n);
      qb.push_back(use_tbl ? tb_b : f_base(a, b));
      qi.push_back(use_tbl ? tb_i : ~f_base(a, b));
      qw.push_back(f_wide(a, b));
    end
    cyc_n++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 3'b0, ordy, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs[6];
  logic [31:0] ra;
  logic [2:0]  rb;

  initial begin
    vecs[0] = '{32'h0000_00F0, 3'b000, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_007E, 3'b000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_000F, 3'b000, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0000, 3'b001, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_00FF, 3'b000, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0000, 3'b000, 1'b0, 1'b1};

    cyc_n = 0; last_acc = 0; last_rdy = 0;
    clear_model();
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; cnt_clr = 1'b0; a_in = '0; b_in = '0;
    #1;
    chk("reset_out_valid", ov_b, 0);
    chk("reset_x", x_b, 0);
    chk("reset_x_inv", x_i, 0);
    chk("reset_hi_count", hc_b, 0);
    @(posedge CLK); @(posedge CLK); #1;
    rst_n = 1'b1;

    // Function table, back-to-back with the consumer always ready.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, vecs[i].a, vecs[i].b, 1'b1, 1'b0, 1'b1, vecs[i].x_base, vecs[i].x_inv);
    idle(3, 1'b1);
    chk("table_hi_count_base", hc_b, 4);
    chk("table_hi_count_inv", hc_i, 2);

    // Back-pressure: two accepted, third blocked until the consumer frees a slot.
    cyc(1'b1, 32'h0F, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h70, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hF0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_third_blocked", last_acc, 0);
    chk("bp_in_ready_low", last_rdy, 0);
    cyc(1'b1, 32'hF0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_x_frozen", x_b, 1);
    cyc(1'b1, 32'hF0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_third_taken_on_ready", last_acc, 1);
    idle(4, 1'b1);

    // Saturation of the 2-bit counter in the inverted build, then clear against a delivery.
    cyc(1'b0, 32'h0, 3'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);
    chk("sat_hi_count_inv", hc_i, 3);
    cyc(1'b1, 32'h0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 3'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_beats_inc_inv", hc_i, 0);
    idle(2, 1'b1);

    // Asynchronous reset with data in flight, then first-transaction latency.
    cyc(1'b1, 32'hFF, 3'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hFF, 3'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hFF, 3'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", ov_b, 0);
    chk("midreset_x", x_b, 0);
    chk("midreset_hi_count", hc_b, 0);
    clear_model();
    @(posedge CLK); #1;
    rst_n = 1'b1;
    cyc(1'b1, 32'hF0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_n1_not_valid", ov_b, 0);
    cyc(1'b0, 32'h0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_n2_valid", ov_b, 1);
    chk("lat_n2_x", x_b, 1);
    idle(2, 1'b1);

    // Random traffic with random stalls.
    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < 4; k++)
        ra[8*k +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      cyc($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0,
          $urandom_range(0, 199) == 0, 1'b0, 1'b0, 1'b0);
    end
    idle(4, 1'b1);
    chk("final_hi_count_wide", hc_w, cnt_w);
    chk("final_drained", ov_w, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
